exu_mdu_ctrl: RTL
=================

Name: exu_mdu_ctrl

Overview:
EX-stage initiator for the multi-cycle M-extension units. It accepts one MUL/DIV-class request from dispatch and drives the start/ready protocol of the Booth multiplier and the divider. It returns results through a one-entry writeback holding buffer and publishes busy/destination information to the hazard logic. Divide-by-zero and signed overflow are resolved locally without starting the divider.

Parameters:
DATA_W, 32, operand/result width (`REG_DATA_WIDTH)
ADDR_W, 5, register address width (`REG_ADDR_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid_i  in  1  dispatch offers an M-op
req_ready_o  out  1  request accepted when valid&ready
req_op_i  in  3  funct3: 0-3 MUL/MULH/MULHSU/MULHU, 4-7 DIV/DIVU/REM/REMU
req_rs1_i  in  DATA_W  rs1 value
req_rs2_i  in  DATA_W  rs2 value
req_waddr_i  in  ADDR_W  destination register
flush_i  in  1  kill in-flight op
mul_start_o  out  1  multiplier start (level, held)
mul_op_o  out  3  multiplier op
mul_a_o / mul_b_o  out  DATA_W  multiplicand / multiplier
mul_ready_i  in  1  multiplier done pulse
mul_result_i  in  DATA_W  multiplier result
div_start_o  out  1  divider start (level, held)
div_op_o  out  3  divider op
div_a_o / div_b_o  out  DATA_W  dividend / divisor
div_ready_i  in  1  divider done pulse
div_result_i  in  DATA_W  divider result
wb_valid_o  out  1  result valid
wb_data_o  out  DATA_W  result
wb_waddr_o  out  ADDR_W  result destination
wb_ready_i  in  1  writeback arbiter accepts
busy_o  out  1  op pending (state != IDLE)
busy_waddr_o  out  ADDR_W  destination of pending op

Behaviour:
- Reset: state IDLE. wb_valid_o=0, busy_o=0, start outputs 0, all data/addr outputs 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, WB_HOLD.
- req_ready_o = !flush_i & (IDLE | (WB_HOLD & wb_ready_i)).
- On accept, register op, rs1, rs2 and waddr. op[2]=0 goes to MUL_WAIT. op[2]=1 with rs2==0 or signed overflow goes to WB_HOLD. Any other op[2]=1 goes to DIV_WAIT.
- Signed overflow: DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF.
- Local results:
  - DIV/DIVU by 0: 0xFFFFFFFF.
  - REM/REMU by 0: rs1.
  - DIV overflow: 0x80000000.
  - REM overflow: 0.
- Start is combinational, not registered: mul_start_o = MUL_WAIT & !mul_ready_i & !flush_i. div_start_o has the same form.
  - Start must drop in the same cycle ready is seen. The units restart if start is still high while they sit in IDLE.
- Operand outputs: driven from registers and stable throughout the WAIT states.
- Unit done: in MUL_WAIT with mul_ready_i (or DIV_WAIT with div_ready_i), capture the result into wb_data_o and go to WB_HOLD.
- WB_HOLD: wb_valid_o=1. Data and address are held until wb_ready_i, then go to IDLE.
  - If a new request is accepted in the same cycle, go directly to that request's next state.
- Latency: request accepted in cycle T → start high from T+1.
  - 16-iteration multiplier: mul_ready_i seen at T+19, wb_valid_o at T+20.
  - Local div results: wb_valid_o at T+1.
- Flush: in any state, go to IDLE next cycle. Start drops combinationally in the flush cycle, wb_valid_o clears, the result is discarded.
  - Flush beats a coincident ready_i, wb_ready_i or req_valid_i.
  - Next accept is no earlier than the cycle after the flush.
- Ignore a ready pulse from a unit not being waited on.
- Reset mid-operation: start drops in the first reset cycle. No result is produced.

Decomposition:
- Shared defines: funct3 op encodings (`INST_MUL…`INST_REMU), state localparams, `ZeroWord, `RstEnable.
- One sub-module: exu_div_special. Combinational; takes op, rs1, rs2 and returns is_special and the special result.
- Handshake FSM stays in exu_mdu_ctrl.

Test Plan:
- MULHU 0xFFFFFFFF×0xFFFFFFFF with a 20-cycle model unit → mul_start_o high T+1..T+18, low at T+19; wb_data_o=0xFFFFFFFE, waddr=5 at T+20.
- DIV 7/0, REMU 9/0, DIV 0x80000000/0xFFFFFFFF → wb_valid_o at T+1 with 0xFFFFFFFF, 9, 0x80000000; div_start_o never asserts.
- DIVU 100/7, model responds after 33 cycles, wb_ready_i low for 3 cycles → wb_data_o=14 held stable, busy_o=1 until wb_ready_i.
- Flush at T+5 of a MUL → mul_start_o low same cycle; no wb_valid_o; a MUL accepted at T+6 restarts cleanly with the correct product.
- Back-to-back: wb_ready_i and req_valid_i together in WB_HOLD → accepted; the next start asserts the following cycle; both results written in order.
- mul_ready_i coincident with flush_i → result discarded, IDLE, wb_valid_o stays 0.

Source files
------------

// File: rtl/exu_mdu_ctrl_pkg.sv
// Shared encodings and helpers for the EX-stage M-extension initiator.
package exu_mdu_ctrl_pkg;

    localparam int unsigned MDU_DATA_W = 32;
    localparam int unsigned MDU_ADDR_W = 5;
    localparam int unsigned MDU_OP_W   = 3;

    // funct3 encodings of the M-extension ops
    localparam logic [MDU_OP_W-1:0] INST_MUL    = 3'd0;
    localparam logic [MDU_OP_W-1:0] INST_MULH   = 3'd1;
    localparam logic [MDU_OP_W-1:0] INST_MULHSU = 3'd2;
    localparam logic [MDU_OP_W-1:0] INST_MULHU  = 3'd3;
    localparam logic [MDU_OP_W-1:0] INST_DIV    = 3'd4;
    localparam logic [MDU_OP_W-1:0] INST_DIVU   = 3'd5;
    localparam logic [MDU_OP_W-1:0] INST_REM    = 3'd6;
    localparam logic [MDU_OP_W-1:0] INST_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_WB_HOLD  = 2'd3
    } mdu_state_e;

    function automatic logic op_is_mul(input logic [MDU_OP_W-1:0] op);
        return (op == INST_MUL) || (op == INST_MULH) ||
               (op == INST_MULHSU) || (op == INST_MULHU);
    endfunction

    function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
        return (op == INST_DIV) || (op == INST_DIVU) ||
               (op == INST_REM) || (op == INST_REMU);
    endfunction

    function automatic logic op_is_rem(input logic [MDU_OP_W-1:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

    function automatic logic op_is_signed_div(input logic [MDU_OP_W-1:0] op);
        return (op == INST_DIV) || (op == INST_REM);
    endfunction

endpackage

// File: rtl/exu_mdu_ctrl_div_special.sv
// Detects divide-by-zero and signed overflow and produces their architectural result.
module exu_div_special
    import exu_mdu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = MDU_DATA_W
) (
    input  logic [MDU_OP_W-1:0] op_i,
    input  logic [DATA_W-1:0]   rs1_i,
    input  logic [DATA_W-1:0]   rs2_i,
    output logic                is_special_c_o,
    output logic [DATA_W-1:0]   result_c_o
);

    localparam logic [DATA_W-1:0] MIN_INT = {1'b1, {(DATA_W-1){1'b0}}};

    logic div_by_zero;
    logic sign_ovf;

    // Classify the request and pick the locally resolved result
    always_comb begin
        div_by_zero    = (rs2_i == '0);
        sign_ovf       = op_is_signed_div(op_i) && (rs1_i == MIN_INT) && (rs2_i == '1);
        is_special_c_o = op_is_div(op_i) && (div_by_zero || sign_ovf);
        result_c_o     = '0;
        if (div_by_zero) begin
            result_c_o = op_is_rem(op_i) ? rs1_i : '1;
        end else if (sign_ovf) begin
            result_c_o = op_is_rem(op_i) ? '0 : MIN_INT;
        end
    end

endmodule

// File: rtl/exu_mdu_ctrl.sv
// EX-stage initiator for the Booth multiplier and divider with a one-entry writeback buffer.
module exu_mdu_ctrl
    import exu_mdu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = MDU_DATA_W,
    parameter int unsigned ADDR_W = MDU_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [MDU_OP_W-1:0] req_op_i,
    input  logic [DATA_W-1:0]   req_rs1_i,
    input  logic [DATA_W-1:0]   req_rs2_i,
    input  logic [ADDR_W-1:0]   req_waddr_i,
    input  logic                flush_i,
    output logic                mul_start_o,
    output logic [MDU_OP_W-1:0] mul_op_o,
    output logic [DATA_W-1:0]   mul_a_o,
    output logic [DATA_W-1:0]   mul_b_o,
    input  logic                mul_ready_i,
    input  logic [DATA_W-1:0]   mul_result_i,
    output logic                div_start_o,
    output logic [MDU_OP_W-1:0] div_op_o,
    output logic [DATA_W-1:0]   div_a_o,
    output logic [DATA_W-1:0]   div_b_o,
    input  logic                div_ready_i,
    input  logic [DATA_W-1:0]   div_result_i,
    output logic                wb_valid_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic [ADDR_W-1:0]   wb_waddr_o,
    input  logic                wb_ready_i,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   busy_waddr_o
);

    mdu_state_e          state_q, state_d;
    logic [MDU_OP_W-1:0] op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;

    logic                accept;
    logic                special;
    logic [DATA_W-1:0]   special_res;

    exu_div_special #(
        .DATA_W (DATA_W)
    ) u_div_special (
        .op_i           (req_op_i),
        .rs1_i          (req_rs1_i),
        .rs2_i          (req_rs2_i),
        .is_special_c_o (special),
        .result_c_o     (special_res)
    );

    // Handshake: accept when idle or when the held result drains this cycle; starts drop with ready
    always_comb begin
        req_ready_o = !rst && !flush_i &&
                      ((state_q == ST_IDLE) || ((state_q == ST_WB_HOLD) && wb_ready_i));
        accept      = req_valid_i && req_ready_o;
        mul_start_o = !rst && (state_q == ST_MUL_WAIT) && !mul_ready_i && !flush_i;
        div_start_o = !rst && (state_q == ST_DIV_WAIT) && !div_ready_i && !flush_i;
    end

    // Next-state: flush wins over every completion, drain or accept
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        waddr_d   = waddr_q;
        wb_data_d = wb_data_q;

        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_MUL_WAIT: begin
                    if (mul_ready_i) begin
                        wb_data_d = mul_result_i;
                        state_d   = ST_WB_HOLD;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_ready_i) begin
                        wb_data_d = div_result_i;
                        state_d   = ST_WB_HOLD;
                    end
                end
                ST_WB_HOLD: begin
                    if (wb_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase

            if (accept) begin
                op_d    = req_op_i;
                a_d     = req_rs1_i;
                b_d     = req_rs2_i;
                waddr_d = req_waddr_i;
                if (op_is_mul(req_op_i)) begin
                    state_d = ST_MUL_WAIT;
                end else if (special) begin
                    wb_data_d = special_res;
                    state_d   = ST_WB_HOLD;
                end else begin
                    state_d = ST_DIV_WAIT;
                end
            end
        end
    end

    // State and operand/result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            waddr_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            waddr_q   <= waddr_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Unit operands and writeback fields come straight from the registers
    always_comb begin
        mul_op_o     = op_q;
        mul_a_o      = a_q;
        mul_b_o      = b_q;
        div_op_o     = op_q;
        div_a_o      = a_q;
        div_b_o      = b_q;
        wb_valid_o   = (state_q == ST_WB_HOLD);
        wb_data_o    = wb_data_q;
        wb_waddr_o   = waddr_q;
        busy_o       = (state_q != ST_IDLE);
        busy_waddr_o = waddr_q;
    end

endmodule
